// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the fetch, load/store and memory-port signals that
//               meet at mem_arbiter.
//               slave  - the arbiter's view: it takes requests from both
//                        requesters and drives the memory port.
//               master - the surrounding system's view: requesters and memory.
//               Signal groups:
//                 if_*  : instruction-fetch requester
//                 d_*   : load/store requester
//                 mem_* : shared memory port
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    // fetch requester
    logic              if_req;
    logic [XLEN-1:0]   if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [XLEN-1:0]   if_rdata;
    // load/store requester
    logic              d_req;
    logic              d_we;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN/8-1:0] d_wmask;
    logic              d_gnt;
    logic              d_rvalid;
    logic [XLEN-1:0]   d_rdata;
    // memory port
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wmask;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wmask,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wmask,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between instruction fetch and
//               load/store. One transaction in flight at a time: grant in
//               IDLE, drive the latched payload in REQ until mem_gnt, wait for
//               mem_rvalid in RESP and route it back to the owner. Data wins
//               by default; a starvation counter forces a fetch grant after
//               MAX_DATA_BURST consecutive data grants with fetch pending.
// Ports       : clk, rst (async, active-high)
//               bus  - mem_arbiter_if.slave (fetch, load/store, memory port)
//               perf_if_grants, perf_d_grants, perf_wait_cycles
//                    - only when MEM_ARBITER_PERF_EN is defined
// Config      : `define MEM_ARBITER_PERF_EN to add the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MEM_ARBITER_PERF_EN
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_wait_cycles,
`endif
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_D   = 1'b1;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);
    localparam logic [3:0] STARVE_MAX  = 4'd15;

    logic [1:0]        state;
    logic              owner;
    logic              lat_we;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic [XLEN/8-1:0] lat_wmask;
    logic [3:0]        starve;

    logic              d_win;
    logic              if_win;
    logic              in_idle;

    // Arbitration: data wins unless fetch has waited out a full data burst.
    always_comb begin
        in_idle = (state == ST_IDLE);
        d_win   = in_idle && bus.d_req && (!bus.if_req || (starve < BURST_LIMIT));
        if_win  = in_idle && bus.if_req && !d_win;
    end

    assign bus.if_gnt    = if_win;
    assign bus.d_gnt     = d_win;

    assign bus.mem_req   = (state == ST_REQ);
    assign bus.mem_we    = (state == ST_REQ) && lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_wmask = lat_wmask;

    // Responses are only routed in RESP; stray mem_rvalid elsewhere is dropped.
    assign bus.if_rvalid = (state == ST_RESP) && bus.mem_rvalid && (owner == OWN_IF);
    assign bus.d_rvalid  = (state == ST_RESP) && bus.mem_rvalid && (owner == OWN_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            starve    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (d_win) begin
                        owner     <= OWN_D;
                        lat_we    <= bus.d_we;
                        lat_addr  <= bus.d_addr;
                        lat_wdata <= bus.d_wdata;
                        // loads never carry byte enables onto the memory port
                        lat_wmask <= bus.d_we ? bus.d_wmask : '0;
                        state     <= ST_REQ;
                        if (bus.if_req) begin
                            if (starve != STARVE_MAX) begin
                                starve <= starve + 4'd1;
                            end
                        end else begin
                            starve <= 4'd0;
                        end
                    end else if (if_win) begin
                        owner     <= OWN_IF;
                        lat_we    <= 1'b0;
                        lat_addr  <= bus.if_addr;
                        lat_wdata <= '0;
                        lat_wmask <= '0;
                        starve    <= 4'd0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_gnt) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.mem_rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_grants   <= 32'd0;
            perf_d_grants    <= 32'd0;
            perf_wait_cycles <= 32'd0;
        end else begin
            if (if_win) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (d_win) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if ((bus.if_req || bus.d_req) && !(if_win || d_win)) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter: reset values,
//               single load, stalled store, fetch/data contention, fetch with
//               stalled response, and asynchronous reset mid-transaction.
//               With MEM_ARBITER_PERF_EN defined the performance counters are
//               checked across the contention run as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_arbiter_if #(.XLEN(32)) bus ();

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_wait_cycles;
`endif

    mem_arbiter #(
        .XLEN           (32),
        .MAX_DATA_BURST (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
`ifdef MEM_ARBITER_PERF_EN
        .perf_if_grants   (perf_if_grants),
        .perf_d_grants    (perf_d_grants),
        .perf_wait_cycles (perf_wait_cycles),
`endif
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        exp_d;
`ifdef MEM_ARBITER_PERF_EN
        logic [31:0] snap_if, snap_d, snap_w;
`endif
        checks   = 0;
        failures = 0;

        rst            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_wmask    = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        // ---------------- reset values ----------------
        #3;
        chk("rst_if_gnt",   bus.if_gnt,    0);
        chk("rst_d_gnt",    bus.d_gnt,     0);
        chk("rst_mem_req",  bus.mem_req,   0);
        chk("rst_mem_we",   bus.mem_we,    0);
        chk("rst_mem_addr", bus.mem_addr,  0);
        chk("rst_mem_wm",   bus.mem_wmask, 0);
        chk("rst_d_rvalid", bus.d_rvalid,  0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---------------- single load, zero wait ----------------
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h100;
        bus.d_wmask = 4'hF;               // ignored for a load
        #1;
        chk("ld_d_gnt",  bus.d_gnt,  1);
        chk("ld_if_gnt", bus.if_gnt, 0);
        tick();
        bus.d_req = 1'b0;
        #1;
        chk("ld_mem_req",  bus.mem_req,   1);
        chk("ld_mem_addr", bus.mem_addr,  32'h100);
        chk("ld_mem_we",   bus.mem_we,    0);
        chk("ld_mem_wm",   bus.mem_wmask, 0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        #1;
        chk("ld_d_rvalid",  bus.d_rvalid,  1);
        chk("ld_d_rdata",   bus.d_rdata,   32'hDEADBEEF);
        chk("ld_if_rvalid", bus.if_rvalid, 0);
        chk("ld_resp_req",  bus.mem_req,   0);
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("ld_done_rv", bus.d_rvalid, 0);

        // ---------------- store, mem_gnt delayed 3 cycles ----------------
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'h12345678;
        bus.d_wmask = 4'b0011;
        #1;
        chk("st_d_gnt", bus.d_gnt, 1);
        tick();
        // requester is free after the grant; the latch must hold the payload
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'hFFFF_FFFF;
        bus.d_wdata = 32'h0;
        bus.d_wmask = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            bus.mem_gnt = (c == 3);
            #1;
            chk("st_req",   bus.mem_req,   1);
            chk("st_we",    bus.mem_we,    1);
            chk("st_addr",  bus.mem_addr,  32'h200);
            chk("st_wdata", bus.mem_wdata, 32'h12345678);
            chk("st_wmask", bus.mem_wmask, 4'b0011);
            chk("st_nogrant", bus.d_gnt,   0);
            tick();
        end
        bus.mem_gnt = 1'b0;
        #1;
        chk("st_wait_rv", bus.d_rvalid, 0);
        tick();
        bus.mem_rvalid = 1'b1;
        #1;
        chk("st_ack", bus.d_rvalid, 1);
        chk("st_ack_if", bus.if_rvalid, 0);
        tick();
        bus.mem_rvalid = 1'b0;

        // ---------------- contention: D,D,D,IF,D,D,D,IF ----------------
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h300;
`ifdef MEM_ARBITER_PERF_EN
        snap_if = perf_if_grants;
        snap_d  = perf_d_grants;
        snap_w  = perf_wait_cycles;
`endif
        for (int t = 0; t < 8; t++) begin
            exp_d = ((t % 4) != 3);
            #1;
            chk("ct_d_gnt",  bus.d_gnt,  exp_d);
            chk("ct_if_gnt", bus.if_gnt, !exp_d);
            tick();
            bus.mem_gnt = 1'b1;
            #1;
            chk("ct_addr", bus.mem_addr, exp_d ? 32'h300 : 32'h40);
            chk("ct_req_nogrant", bus.d_gnt | bus.if_gnt, 0);
            tick();
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hA000_0000 + t;
            #1;
            chk("ct_d_rv",  bus.d_rvalid,  exp_d);
            chk("ct_if_rv", bus.if_rvalid, !exp_d);
            tick();
            bus.mem_rvalid = 1'b0;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
`ifdef MEM_ARBITER_PERF_EN
        #1;
        chk("perf_d",    perf_d_grants    - snap_d,  6);
        chk("perf_if",   perf_if_grants   - snap_if, 2);
        chk("perf_wait", perf_wait_cycles - snap_w,  16);
`endif
        tick();

        // ---------------- fetch with stalled response ----------------
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        #1;
        chk("fs_if_gnt", bus.if_gnt, 1);
        chk("fs_d_gnt",  bus.d_gnt,  0);
        tick();
        bus.if_req  = 1'b0;
        bus.mem_gnt = 1'b1;
        #1;
        chk("fs_addr", bus.mem_addr, 32'h0);
        chk("fs_we",   bus.mem_we,   0);
        tick();
        bus.mem_gnt = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h400;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("fs_wait_dgnt", bus.d_gnt,     0);
            chk("fs_wait_ifrv", bus.if_rvalid, 0);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE0001;
        #1;
        chk("fs_if_rv",    bus.if_rvalid, 1);
        chk("fs_if_rdata", bus.if_rdata,  32'hCAFE0001);
        chk("fs_d_rv",     bus.d_rvalid,  0);
        chk("fs_rv_dgnt",  bus.d_gnt,     0);
        tick();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("fs_after_dgnt", bus.d_gnt,     1);
        chk("fs_after_ifrv", bus.if_rvalid, 0);
        tick();
        bus.d_req   = 1'b0;
        bus.mem_gnt = 1'b1;
        #1;
        chk("fs_d_addr", bus.mem_addr, 32'h400);
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        #1;
        chk("fs_d_done", bus.d_rvalid, 1);
        tick();
        bus.mem_rvalid = 1'b0;

        // ---------------- reset during RESP ----------------
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h500;
        #1;
        chk("mr_d_gnt", bus.d_gnt, 1);
        tick();
        bus.d_req   = 1'b0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        #1;
        chk("mr_pre_rv", bus.d_rvalid, 1);
        rst = 1'b1;
        #1;
        chk("mr_rv_drop",  bus.d_rvalid,  0);
        chk("mr_if_rv",    bus.if_rvalid, 0);
        chk("mr_mem_req",  bus.mem_req,   0);
        chk("mr_mem_addr", bus.mem_addr,  0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_idle_rv", bus.d_rvalid, 0);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h80;
        #1;
        chk("mr_next_gnt", bus.if_gnt, 1);
        tick();
        bus.if_req  = 1'b0;
        bus.mem_gnt = 1'b1;
        #1;
        chk("mr_next_addr", bus.mem_addr, 32'h80);
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        #1;
        chk("mr_next_rv", bus.if_rvalid, 1);
        tick();
        bus.mem_rvalid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port of the RV32 core between the instruction-fetch requester and the load/store requester. It accepts one transaction at a time and latches its payload. It drives that transaction on the memory port with a req/gnt handshake, then routes the response back to the requester that issued it. Data accesses win by default; a starvation counter forces a fetch grant after a bounded run of data grants.

## Interface
Parameters:
- XLEN, 32, data/address width
- MAX_DATA_BURST, 3, consecutive data grants allowed while if_req is pending (1..15)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted, if_addr sampled this edge
- if_rvalid  out  1  fetch response valid (one cycle)
- if_rdata  out  XLEN  fetch data, valid with if_rvalid
- d_req  in  1  load/store request; held with payload stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_wmask  in  XLEN/8  store byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  data response valid (load data or store ack)
- d_rdata  out  XLEN  load data, valid with d_rvalid
- mem_req  out  1  memory request; held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  XLEN  address
- mem_wdata  out  XLEN  write data
- mem_wmask  out  XLEN/8  byte enables (0 for reads)
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  XLEN  memory read data

## Operation
- FSM states: IDLE, REQ, RESP. Registers: owner (IF/D), latched we/addr/wdata/wmask, starve counter (4 bits).
- IDLE, arbitration (combinational, registered at the edge):
  - The data requester wins when d_req=1 and (if_req=0 or starve < MAX_DATA_BURST).
  - Otherwise fetch wins when if_req=1.
  - The winner's gnt is asserted in this cycle. The payload and owner are latched at the edge, and the FSM goes to REQ.
  - A fetch latches we=0 and wmask=0.
- Starve counter:
  - Increments on a data grant while if_req=1, saturating at 15.
  - Clears on any fetch grant, and on a data grant while if_req=0.
- REQ: mem_req=1 with the latched fields. On mem_gnt=1 go to RESP.
- RESP: wait for mem_rvalid.
  - When it arrives, owner's rvalid = 1 in the same cycle (combinational).
  - The owner's rdata = mem_rdata.
  - FSM returns to IDLE.
- Stores also complete with mem_rvalid; d_rvalid is the store ack and d_rdata is don't-care.
- if_rdata and d_rdata are both wired to mem_rdata; only the qualifying rvalid matters.
- mem_rvalid in IDLE or REQ is ignored and not routed.
- mem_gnt outside REQ is ignored.
- At most one gnt per IDLE visit, so there is never more than one outstanding transaction.

## Timing
- Reset values:
  - FSM = IDLE, starve = 0, owner = IF.
  - All gnt, rvalid, mem_req and mem_we outputs = 0.
  - mem_addr, mem_wdata and mem_wmask = 0.
- Reset asserted mid-transaction: outputs drop asynchronously. Any later mem_rvalid for the lost transaction is discarded (FSM is in IDLE). Requesters must reissue.
- Zero-wait memory (mem_gnt in the first REQ cycle, mem_rvalid in the first RESP cycle):
  - Cycle 0: gnt.
  - Cycle 1: mem_req.
  - Cycle 2: rvalid.
  - Cycle 3: next grant possible.
  - Throughput is one transaction per 3 cycles.
- A memory stall in REQ or RESP holds the state; the latched payload stays stable on mem_* throughout REQ.
- if_req and d_req both asserted in IDLE: exactly one gnt fires, selected per the arbitration rule; the loser stays pending.
- Requests that arrive while not in IDLE are not granted until the FSM returns to IDLE.

## Configuration
- MEM_ARBITER_PERF_EN defined: adds three outputs, each 32 bits, counting up and wrapping, reset to 0:
  - perf_if_grants: +1 per if_gnt.
  - perf_d_grants: +1 per d_gnt.
  - perf_wait_cycles: +1 per cycle where (if_req | d_req) and no gnt.
- MEM_ARBITER_PERF_EN undefined: these ports and their counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Single load:
  - Stimulus: d_req, d_addr=0x100, memory returns 0xDEADBEEF with zero wait.
  - Response: d_gnt at cycle 0, mem_req/mem_addr=0x100 at cycle 1, d_rvalid with d_rdata=0xDEADBEEF at cycle 2, if_rvalid never asserted.
- Store:
  - Stimulus: d_we=1, d_addr=0x200, d_wdata=0x12345678, d_wmask=4'b0011, mem_gnt delayed 3 cycles.
  - Response: mem_* fields are stable for all 4 REQ cycles; d_rvalid follows mem_rvalid.
- Contention:
  - Stimulus: if_req and d_req held high continuously with MAX_DATA_BURST=3.
  - Response: grant order D,D,D,IF,D,D,D,IF…
- Fetch with a stalled response:
  - Stimulus: if_req, if_addr=0x0, mem_rvalid delayed 5 cycles, d_req raised during the wait.
  - Response: no d_gnt until after if_rvalid; if_rvalid is asserted exactly once.
- Mid-transaction reset:
  - Stimulus: rst pulsed while in RESP, then mem_rvalid=1.
  - Response: outputs are 0 immediately, no rvalid is emitted, and the next request is granted normally.
- Performance counters (MEM_ARBITER_PERF_EN defined):
  - Stimulus: rerun the contention scenario for 8 transactions.
  - Response: perf_d_grants=6, perf_if_grants=2, perf_wait_cycles matches the count of pending-but-ungranted cycles.
